// File: rtl/packet_source_pkg.sv
// Shared constants, state encoding and elaboration helpers for the packet source.
package packet_source_pkg;

  typedef enum logic [1:0] {
    STATE_IDLE = 2'd0,
    STATE_HEAD = 2'd1,
    STATE_BODY = 2'd2
  } state_t;

  localparam int PKT_CNT_LSB_OFS = 5;
  localparam int PKT_CNT_WIDTH   = 32;
  localparam int SRC_ADDR_WIDTH  = 2;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
`ifdef PACKET_SOURCE_TIMESTAMP_EN
  localparam int TIMESTAMP_WIDTH = 32;
`endif

  function automatic int clogb(input int value);
    int n;
    n = 0;
    while ((1 << n) < value) n = n + 1;
    return n;
  endfunction

  function automatic int at_least_one(input int value);
    return (value < 1) ? 1 : value;
  endfunction

endpackage

// File: rtl/packet_source_credit_ctr.sv
// Per-VC credit counter: decrements on flit issue, increments on returned credit, flags overflow.
module packet_source_credit_ctr
  import packet_source_pkg::*;
#(
  parameter int max_credits = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic consume,
  input  logic credit_return,
  output logic nonzero,
  output logic error
);

  localparam int cw = clogb(max_credits + 1);
  localparam logic [cw-1:0] full = cw'(max_credits);

  logic [cw-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= full;
      error <= 1'b0;
    end else begin
      case ({consume, credit_return})
        2'b10: count <= count - cw'(1);
        2'b01: begin
          if (count == full) error <= 1'b1;
          else               count <= count + cw'(1);
        end
        default: ;
      endcase
    end
  end

  assign nonzero = (count != '0);

endmodule

// File: rtl/packet_source.sv
// Credit-flow-controlled packet injector; PACKET_SOURCE_TIMESTAMP_EN adds a cycle stamp to payload flits.
module packet_source
  import packet_source_pkg::*;
#(
  parameter int num_vcs            = 8,
  parameter int buffer_size        = 64,
  parameter int flit_data_width    = 64,
  parameter int route_info_width   = 14,
  parameter int max_payload_length = 4,
  parameter int min_payload_length = 1,
  parameter int enable_link_pm     = 1,
  parameter int inject_rate        = 26,
  parameter logic [15:0] lfsr_seed = 16'hACE1,
  parameter int src_dim1           = 0,
  parameter int src_dim2           = 0
) (
  input  logic                                                   clk,
  input  logic                                                   reset,
  input  logic                                                   enable,
  input  logic [route_info_width-1:0]                            dest_route,
  input  logic [clogb(num_vcs):0]                                flow_ctrl,
  output logic [enable_link_pm+clogb(num_vcs)+flit_data_width+1:0] channel,
  output logic [31:0]                                            pkt_count,
  output logic                                                   busy,
  output logic                                                   error
);

  localparam int vc_w      = clogb(num_vcs);
  localparam int len_range = max_payload_length - min_payload_length + 1;
  localparam int len_w     = at_least_one(clogb(len_range));
  localparam int rem_w     = at_least_one(clogb(max_payload_length + 1));
  localparam int pkt_lsb   = flit_data_width - PKT_CNT_LSB_OFS - PKT_CNT_WIDTH + 1;
  localparam int src1_lsb  = flit_data_width - 2 * SRC_ADDR_WIDTH;
  localparam int src2_lsb  = flit_data_width - SRC_ADDR_WIDTH;

  state_t                        state;
  logic [15:0]                   lfsr;
  logic [vc_w-1:0]               vc_q, last_vc, pick, cand;
  logic [route_info_width-1:0]   route_q;
  logic [len_w-1:0]              len_off, len_off_q;
  logic [rem_w-1:0]              remaining;
  logic [31:0]                   pkt_cnt;
  logic [num_vcs-1:0]            nonzero, err, consume, ret;
  logic                          start, send, found;
  logic [flit_data_width-1:0]    flit_data;
  logic                          vld_p1, head_p1, link_p1;
  logic [vc_w-1:0]               vc_p1;
  logic [flit_data_width-1:0]    data_p1;

  assign start   = enable && (int'(lfsr[7:0]) < inject_rate) && (|nonzero);
  assign send    = (state != STATE_IDLE) && nonzero[vc_q];
  assign len_off = len_w'(int'(lfsr[15:8]) % len_range);

  for (genvar v = 0; v < num_vcs; v++) begin : g_credit
    assign consume[v] = send && (vc_q == vc_w'(v));
    assign ret[v]     = flow_ctrl[0] && (flow_ctrl[vc_w:1] == vc_w'(v));
    packet_source_credit_ctr #(.max_credits(buffer_size / num_vcs)) u_ctr (
      .clk          (clk),
      .reset        (reset),
      .consume      (consume[v]),
      .credit_return(ret[v]),
      .nonzero      (nonzero[v]),
      .error        (err[v])
    );
  end

  // Round-robin: first VC with credit, searching upward from the one after the last used
  always_comb begin
    pick  = '0;
    cand  = '0;
    found = 1'b0;
    for (int i = 1; i <= num_vcs; i++) begin
      cand = vc_w'((int'(last_vc) + i) % num_vcs);
      if (!found && nonzero[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

`ifdef PACKET_SOURCE_TIMESTAMP_EN
  logic [TIMESTAMP_WIDTH-1:0] cycle_cnt;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cycle_cnt <= '0;
    else       cycle_cnt <= cycle_cnt + TIMESTAMP_WIDTH'(1);
  end
`endif

  always_comb begin
    flit_data = '0;
    if (state == STATE_HEAD) begin
      flit_data[route_info_width-1:0]     = route_q;
      flit_data[route_info_width +: len_w] = len_off_q;
    end else begin
      flit_data[pkt_lsb +: PKT_CNT_WIDTH]   = pkt_cnt;
      flit_data[src1_lsb +: SRC_ADDR_WIDTH] = SRC_ADDR_WIDTH'(src_dim1);
      flit_data[src2_lsb +: SRC_ADDR_WIDTH] = SRC_ADDR_WIDTH'(src_dim2);
`ifdef PACKET_SOURCE_TIMESTAMP_EN
      flit_data[pkt_lsb-TIMESTAMP_WIDTH +: TIMESTAMP_WIDTH] = cycle_cnt;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= STATE_IDLE;
      lfsr      <= lfsr_seed;
      vc_q      <= '0;
      last_vc   <= vc_w'(num_vcs - 1);
      route_q   <= '0;
      len_off_q <= '0;
      remaining <= '0;
      pkt_cnt   <= '0;
      vld_p1    <= 1'b0;
      head_p1   <= 1'b0;
      link_p1   <= 1'b0;
      vc_p1     <= '0;
      data_p1   <= '0;
    end else begin
      lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
      // Stage boundary: flit decided this cycle is presented on the channel after the edge
      vld_p1  <= send;
      head_p1 <= send && (state == STATE_HEAD);
      vc_p1   <= send ? vc_q : '0;
      data_p1 <= send ? flit_data : '0;
      link_p1 <= (state != STATE_IDLE) || start;
      case (state)
        STATE_IDLE: begin
          if (start) begin
            state     <= STATE_HEAD;
            vc_q      <= pick;
            last_vc   <= pick;
            route_q   <= dest_route;
            len_off_q <= len_off;
            remaining <= rem_w'(min_payload_length + int'(len_off));
          end
        end
        STATE_HEAD: begin
          if (send) begin
            if (remaining == '0) begin
              pkt_cnt <= pkt_cnt + 32'd1;
              state   <= STATE_IDLE;
            end else begin
              state <= STATE_BODY;
            end
          end
        end
        STATE_BODY: begin
          if (send) begin
            remaining <= remaining - rem_w'(1);
            if (remaining == rem_w'(1)) begin
              pkt_cnt <= pkt_cnt + 32'd1;
              state   <= STATE_IDLE;
            end
          end
        end
        default: state <= STATE_IDLE;
      endcase
    end
  end

  if (enable_link_pm != 0) begin : g_link
    assign channel = {link_p1, vld_p1, vc_p1, head_p1, data_p1};
  end else begin : g_nolink
    assign channel = {vld_p1, vc_p1, head_p1, data_p1};
  end

  assign pkt_count = pkt_cnt;
  assign busy      = (state != STATE_IDLE);
  assign error     = |err;

endmodule

// File: tb/tb_packet_source.sv
// Directed bench for packet_source: one instance with 4-flit packets, one with 5-flit packets.
module tb_packet_source;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable_a = 1'b0, enable_b = 1'b0;
  logic [13:0] dest_route = 14'h0;
  logic [3:0]  flow_a = 4'd0, flow_b = 4'd0;
  logic [69:0] channel_a, channel_b;
  logic [31:0] pkt_a, pkt_b;
  logic        busy_a, busy_b, error_a, error_b;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  packet_source #(.min_payload_length(3), .max_payload_length(3), .inject_rate(256)) u_dut_a (
    .clk(clk), .reset(reset), .enable(enable_a), .dest_route(dest_route), .flow_ctrl(flow_a),
    .channel(channel_a), .pkt_count(pkt_a), .busy(busy_a), .error(error_a));

  packet_source #(.min_payload_length(4), .max_payload_length(4), .inject_rate(256)) u_dut_b (
    .clk(clk), .reset(reset), .enable(enable_b), .dest_route(dest_route), .flow_ctrl(flow_b),
    .channel(channel_b), .pkt_count(pkt_b), .busy(busy_b), .error(error_b));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1; enable_a = 1'b0; enable_b = 1'b0; flow_a = 4'd0; flow_b = 4'd0;
    repeat (2) tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) tick();
    checks++; if (channel_a !== 70'd0) begin failures++; $display("FAIL reset_chan_a: got %0h want 0", channel_a); end
    checks++; if (channel_b !== 70'd0) begin failures++; $display("FAIL reset_chan_b: got %0h want 0", channel_b); end
    checks++; if (pkt_b !== 32'd0) begin failures++; $display("FAIL reset_pkt: got %0d want 0", pkt_b); end
    checks++; if ({busy_a, busy_b, error_a, error_b} !== 4'b0) begin failures++; $display("FAIL reset_flags: got %b want 0000", {busy_a, busy_b, error_a, error_b}); end
    reset = 1'b0;
    repeat (2) tick();
    checks++; if (channel_b !== 70'd0) begin failures++; $display("FAIL idle_chan: got %0h want 0", channel_b); end
  endtask

  task automatic test_inject_all_vcs;
    int cnt [8];
    int late;
    logic [2:0] head_q[$];
    for (int v = 0; v < 8; v++) cnt[v] = 0;
    late = 0;
    enable_a = 1'b1;
    for (int cyc = 0; cyc < 200; cyc++) begin
      tick();
      if (channel_a[68]) begin
        cnt[channel_a[67:65]]++;
        if (channel_a[64]) head_q.push_back(channel_a[67:65]);
        if (cyc >= 150) late++;
      end
    end
    enable_a = 1'b0;
    for (int v = 0; v < 8; v++) begin
      checks++; if (cnt[v] != 8) begin failures++; $display("FAIL flits_vc%0d: got %0d want 8", v, cnt[v]); end
    end
    checks++; if (head_q.size() != 16) begin failures++; $display("FAIL head_count: got %0d want 16", head_q.size()); end
    for (int i = 0; i < head_q.size(); i++) begin
      checks++; if (head_q[i] !== 3'(i % 8)) begin failures++; $display("FAIL rr_order[%0d]: got %0d want %0d", i, head_q[i], i % 8); end
    end
    checks++; if (late != 0) begin failures++; $display("FAIL valid_after_drain: got %0d want 0", late); end
    checks++; if (pkt_a !== 32'd16) begin failures++; $display("FAIL pkt_count_a: got %0d want 16", pkt_a); end
    checks++; if (error_a !== 1'b0) begin failures++; $display("FAIL error_a: got %b want 0", error_a); end
  endtask

  task automatic test_loopback;
    int nfl, pos, pk, idle_valid;
    do_reset();
    dest_route = 14'h2A5C;
    enable_b = 1'b1;
    nfl = 0;
    for (int cyc = 0; cyc < 200 && nfl < 15; cyc++) begin
      tick();
      flow_b = channel_b[68] ? {channel_b[67:65], 1'b1} : 4'd0;
      if (channel_b[68]) begin
        pos = nfl % 5;
        pk  = nfl / 5;
        checks++; if (channel_b[64] !== (pos == 0)) begin failures++; $display("FAIL lb_head[%0d]: got %b want %b", nfl, channel_b[64], pos == 0); end
        checks++; if (channel_b[67:65] !== 3'(pk)) begin failures++; $display("FAIL lb_vc[%0d]: got %0d want %0d", nfl, channel_b[67:65], pk); end
        checks++; if (channel_b[69] !== 1'b1) begin failures++; $display("FAIL lb_link[%0d]: got %b want 1", nfl, channel_b[69]); end
        if (pos == 0) begin
          checks++; if (channel_b[63:0] !== {50'd0, 14'h2A5C}) begin failures++; $display("FAIL lb_head_data[%0d]: got %0h want 2a5c", nfl, channel_b[63:0]); end
        end else begin
          checks++; if (channel_b[59:28] !== 32'(pk)) begin failures++; $display("FAIL lb_pkt_idx[%0d]: got %0d want %0d", nfl, channel_b[59:28], pk); end
          checks++; if ({channel_b[63:60], channel_b[27:0]} !== 32'd0) begin failures++; $display("FAIL lb_other_bits[%0d]: got %0h want 0", nfl, {channel_b[63:60], channel_b[27:0]}); end
        end
        if (pos == 4) begin
          checks++; if (pkt_b !== 32'(pk + 1)) begin failures++; $display("FAIL lb_pkt_count[%0d]: got %0d want %0d", nfl, pkt_b, pk + 1); end
        end
        nfl++;
      end
    end
    enable_b = 1'b0;
    tick();
    flow_b = 4'd0;
    checks++; if (nfl != 15) begin failures++; $display("FAIL lb_flits: got %0d want 15", nfl); end
    idle_valid = 0;
    repeat (10) begin tick(); if (channel_b[68]) idle_valid++; end
    checks++; if (idle_valid != 0) begin failures++; $display("FAIL lb_idle_valid: got %0d want 0", idle_valid); end
    checks++; if ({pkt_b, busy_b, error_b} !== {32'd3, 2'b00}) begin failures++; $display("FAIL lb_final: got %0h want %0h", {pkt_b, busy_b, error_b}, {32'd3, 2'b00}); end
  endtask

  task automatic test_same_cycle_credit;
    int nfl;
    do_reset();
    enable_b = 1'b1;
    nfl = 0;
    for (int cyc = 0; cyc < 200 && nfl < 41; cyc++) begin
      tick();
      if (channel_b[68]) nfl++;
    end
    enable_b = 1'b0;
    checks++; if (nfl != 41) begin failures++; $display("FAIL sc_flits: got %0d want 41", nfl); end
    checks++; if ({channel_b[68], channel_b[67:64]} !== 5'b1_000_1) begin failures++; $display("FAIL sc_head_vc0: got %b want 10001", {channel_b[68], channel_b[67:64]}); end
    tick();
    checks++; if (channel_b[68] !== 1'b1) begin failures++; $display("FAIL sc_body1: got %b want 1", channel_b[68]); end
    flow_b = {3'd0, 1'b1};
    tick();
    flow_b = 4'd0;
    checks++; if (channel_b[68] !== 1'b1) begin failures++; $display("FAIL sc_body2: got %b want 1", channel_b[68]); end
    tick();
    checks++; if (channel_b[68] !== 1'b1) begin failures++; $display("FAIL sc_body3_no_stall: got %b want 1", channel_b[68]); end
    tick();
    checks++; if ({channel_b[68], busy_b} !== 2'b01) begin failures++; $display("FAIL sc_stall: got %b want 01", {channel_b[68], busy_b}); end
    flow_b = {3'd0, 1'b1};
    tick();
    flow_b = 4'd0;
    checks++; if (channel_b[68] !== 1'b0) begin failures++; $display("FAIL sc_stall2: got %b want 0", channel_b[68]); end
    tick();
    checks++; if ({channel_b[68], channel_b[64]} !== 2'b10) begin failures++; $display("FAIL sc_tail: got %b want 10", {channel_b[68], channel_b[64]}); end
    checks++; if ({pkt_b, busy_b, error_b} !== {32'd9, 2'b00}) begin failures++; $display("FAIL sc_final: got %0h want %0h", {pkt_b, busy_b, error_b}, {32'd9, 2'b00}); end
  endtask

  task automatic test_credit_overflow;
    do_reset();
    flow_b = {3'd3, 1'b1};
    checks++; if (error_b !== 1'b0) begin failures++; $display("FAIL ov_before: got %b want 0", error_b); end
    tick();
    flow_b = 4'd0;
    checks++; if (error_b !== 1'b1) begin failures++; $display("FAIL ov_set: got %b want 1", error_b); end
    repeat (5) tick();
    checks++; if (error_b !== 1'b1) begin failures++; $display("FAIL ov_sticky: got %b want 1", error_b); end
    do_reset();
    checks++; if (error_b !== 1'b0) begin failures++; $display("FAIL ov_cleared: got %b want 0", error_b); end
  endtask

  task automatic test_enable_drop;
    logic seen;
    int idle_valid;
    do_reset();
    enable_b = 1'b1;
    seen = 1'b0;
    for (int cyc = 0; cyc < 20 && !seen; cyc++) begin
      tick();
      if (channel_b[68] && channel_b[64]) seen = 1'b1;
    end
    enable_b = 1'b0;
    checks++; if (seen !== 1'b1) begin failures++; $display("FAIL ed_head_seen: got %b want 1", seen); end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if ({channel_b[68], channel_b[64]} !== 2'b10) begin failures++; $display("FAIL ed_body%0d: got %b want 10", i, {channel_b[68], channel_b[64]}); end
      checks++; if (busy_b !== (i < 3)) begin failures++; $display("FAIL ed_busy%0d: got %b want %b", i, busy_b, i < 3); end
    end
    checks++; if (pkt_b !== 32'd1) begin failures++; $display("FAIL ed_pkt_count: got %0d want 1", pkt_b); end
    idle_valid = 0;
    repeat (12) begin tick(); if (channel_b[68] || busy_b) idle_valid++; end
    checks++; if (idle_valid != 0) begin failures++; $display("FAIL ed_no_new_head: got %0d want 0", idle_valid); end
  endtask

  task automatic test_reset_mid_body;
    int nfl;
    logic first_seen;
    logic [3:0] first_flit;
    do_reset();
    enable_b = 1'b1;
    nfl = 0;
    for (int cyc = 0; cyc < 20 && nfl < 2; cyc++) begin
      tick();
      if (channel_b[68]) nfl++;
    end
    checks++; if ({nfl[1:0], busy_b} !== 3'b101) begin failures++; $display("FAIL rm_in_body: got %b want 101", {nfl[1:0], busy_b}); end
    #2 reset = 1'b1;
    #1;
    checks++; if (channel_b !== 70'd0) begin failures++; $display("FAIL rm_chan_immediate: got %0h want 0", channel_b); end
    checks++; if ({pkt_b, busy_b} !== 33'd0) begin failures++; $display("FAIL rm_state: got %0h want 0", {pkt_b, busy_b}); end
    tick();
    tick();
    reset = 1'b0;
    nfl = 0;
    first_seen = 1'b0;
    first_flit = 4'd0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      tick();
      if (channel_b[68]) begin
        if (!first_seen) first_flit = channel_b[67:64];
        first_seen = 1'b1;
        nfl++;
      end
    end
    enable_b = 1'b0;
    checks++; if ({first_seen, first_flit} !== 5'b1_000_1) begin failures++; $display("FAIL rm_first_head: got %b want 10001", {first_seen, first_flit}); end
    checks++; if (nfl != 43) begin failures++; $display("FAIL rm_total_flits: got %0d want 43", nfl); end
    checks++; if (pkt_b !== 32'd8) begin failures++; $display("FAIL rm_pkt_count: got %0d want 8", pkt_b); end
  endtask

  initial begin
    test_reset();
    test_inject_all_vcs();
    test_loopback();
    test_same_cycle_credit();
    test_credit_overflow();
    test_enable_drop();
    test_reset_mid_body();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
